bambu_putchar: RTL and testbench

- Bambu HLS external-function implementation of putchar: a hardware "putchar(c)" call pushes one byte into an internal circular buffer, and the buffer drains to the TX byte stream via a valid/ready handshake.
- It is the transmit counterpart of the HLS getchar block and uses the same HLS call handshake: start_port, done_port, return_port.
- It sits between the HLS-generated datapath and the TX serializer.

---
 rtl/bambu_putchar.sv | 121 ++++++++++++
 tb/tb_bambu_putchar.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bambu_putchar.sv
// HLS putchar: each call pushes one byte into a circular buffer that drains to TX via valid/ready.
// Call latency 1 cycle with space (more while full); TX_VALID/TX_DATA hold while TX_READY is low.
module bambu_putchar #(
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start_port,
  input  logic [7:0]    in1,
  output logic          done_port,
  output logic [15:0]   return_port,
  output logic [7:0]    TX_DATA,
  output logic          TX_VALID,
  input  logic          TX_READY,
  output logic [CW-1:0] fifo_count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, DONE} state_e;

  state_e          state_q, state_d;
  logic [7:0]      char_q, char_d;
  logic [15:0]     ret_q, ret_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      tx_dat_q, tx_dat_d;
  logic            tx_vld_q, tx_vld_d;
  logic [7:0]      mem_q [DEPTH];

  logic            full, empty, push, pop;
  logic [7:0]      push_dat;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // Pop only when the output register is free or being drained this cycle.
  assign pop   = !empty && (!tx_vld_q || TX_READY);

  always_comb begin
    state_d  = state_q;
    char_d   = char_q;
    ret_d    = ret_q;
    push     = 1'b0;
    push_dat = char_q;
    case (state_q)
      IDLE: begin
        if (start_port) begin
          char_d   = in1;
          push_dat = in1;
          if (!full) begin
            push    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: begin
        if (!full) begin
          push    = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (push) ret_d = {8'h00, push_dat};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    tx_dat_d = tx_dat_q;
    tx_vld_d = tx_vld_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      tx_dat_d = mem_q[rd_ptr_q];
      tx_vld_d = 1'b1;
    end else if (TX_READY) begin
      tx_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      char_q   <= 8'h00;
      ret_q    <= 16'h0000;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_dat_q <= 8'h00;
      tx_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      char_q   <= char_d;
      ret_q    <= ret_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tx_dat_q <= tx_dat_d;
      tx_vld_q <= tx_vld_d;
    end
  end

  // Storage array carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign done_port   = (state_q == DONE);
  assign return_port = ret_q;
  assign TX_DATA     = tx_dat_q;
  assign TX_VALID    = tx_vld_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_bambu_putchar.sv
// Scoreboard bench for bambu_putchar: calls push expected return/TX bytes, a negedge monitor pops and compares.
module tb_bambu_putchar;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_port = 1'b0;
  logic [7:0]  in1 = 8'h00;
  logic        TX_READY = 1'b0;
  logic        done_port;
  logic [15:0] return_port;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic [4:0]  fifo_count;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [7:0]  exp_tx[$];
  logic [15:0] exp_ret[$];

  logic       prev_vld = 1'b0, prev_rdy = 1'b0, prev_done = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  logic       stim_done = 1'b0;

  bambu_putchar #(.DEPTH(16)) dut (
    .clock(clock), .reset(reset), .start_port(start_port), .in1(in1),
    .done_port(done_port), .return_port(return_port),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whenever the DUT presents a completion or a TX transfer.
  always @(negedge clock) begin
    if (!reset) begin
      prev_vld  = 1'b0;
      prev_rdy  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_vld && !prev_rdy) begin
        chk("tx_hold_vld", {31'd0, TX_VALID}, 32'd1);
        chk("tx_hold_dat", {24'd0, TX_DATA}, {24'd0, prev_dat});
      end
      if (done_port) begin
        done_cnt++;
        chk("done_width", {31'd0, prev_done}, 32'd0);
        if (exp_ret.size() == 0) begin
          checks++; errors++;
          $display("FAIL ret_unexpected: got %0h expected none", return_port);
        end else begin
          chk("return_port", {16'd0, return_port}, {16'd0, exp_ret.pop_front()});
        end
      end
      if (TX_VALID && TX_READY) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %0h expected none", TX_DATA);
        end else begin
          chk("tx_data", {24'd0, TX_DATA}, {24'd0, exp_tx.pop_front()});
        end
      end
      prev_vld  = TX_VALID;
      prev_rdy  = TX_READY;
      prev_done = done_port;
      prev_dat  = TX_DATA;
    end
  end

  // All drivers run at posedge+2; the monitor samples at negedge.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!done_port && lat < 64);
    if (!done_port) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done_port expected pulse");
    end
    @(posedge clock); #2;
  endtask

  task automatic do_call(input logic [7:0] c, output int lat);
    start_port = 1'b1;
    in1 = c;
    exp_ret.push_back({8'h00, c});
    exp_tx.push_back(c);
    @(posedge clock); #2;
    start_port = 1'b0;
    wait_done(lat);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_tx.size() == 0 && exp_ret.size() == 0) break;
      @(negedge clock);
    end
    chk("drain_tx_left", exp_tx.size(), 0);
    chk("drain_ret_left", exp_ret.size(), 0);
    @(posedge clock); #2;
  endtask

  initial begin
    int lat, c0;
    logic [31:0] pat;

    #3;
    chk("rst_done", {31'd0, done_port}, 0);
    chk("rst_ret", {16'd0, return_port}, 0);
    chk("rst_vld", {31'd0, TX_VALID}, 0);
    chk("rst_dat", {24'd0, TX_DATA}, 0);
    chk("rst_cnt", {27'd0, fifo_count}, 0);
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #2;

    // Single call with TX_READY high.
    TX_READY = 1'b1;
    do_call(8'h41, lat);
    chk("single_lat", lat, 1);
    @(negedge clock);
    chk("single_vld", {31'd0, TX_VALID}, 1);
    chk("single_dat", {24'd0, TX_DATA}, 32'h41);
    @(negedge clock);
    chk("single_vld_drop", {31'd0, TX_VALID}, 0);
    @(posedge clock); #2;
    drain();

    // Burst fill with TX_READY low.
    TX_READY = 1'b0;
    for (int i = 0; i < 17; i++) begin
      do_call(8'(i), lat);
      chk("burst_lat", lat, 1);
    end
    chk("burst_cnt", {27'd0, fifo_count}, 16);
    chk("burst_vld", {31'd0, TX_VALID}, 1);
    start_port = 1'b1;
    in1 = 8'h11;
    exp_ret.push_back(16'h0011);
    exp_tx.push_back(8'h11);
    @(posedge clock); #2;
    start_port = 1'b0;
    c0 = done_cnt;
    repeat (4) begin @(posedge clock); #2; end
    chk("stall_no_done", done_cnt, c0);
    chk("stall_cnt", {27'd0, fifo_count}, 16);
    TX_READY = 1'b1;
    wait_done(lat);
    chk("stall_release_lat", lat, 3);
    drain();

    // Simultaneous push and pop with 5 bytes buffered.
    TX_READY = 1'b0;
    for (int i = 0; i < 6; i++) do_call(8'h50 + 8'(i), lat);
    chk("pp_cnt_before", {27'd0, fifo_count}, 5);
    TX_READY = 1'b1;
    start_port = 1'b1;
    in1 = 8'h56;
    exp_ret.push_back(16'h0056);
    exp_tx.push_back(8'h56);
    @(posedge clock); #2;
    start_port = 1'b0;
    chk("pp_cnt_same", {27'd0, fifo_count}, 5);
    wait_done(lat);
    chk("pp_lat", lat, 1);
    drain();

    // Backpressure with a fixed toggling pattern and pointer wrap.
    stim_done = 1'b0;
    pat = 32'hB5A3_9C6E;
    fork
      begin
        for (int i = 0; i < 40; i++) do_call(8'(i * 7 + 3), lat);
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clock); #2;
          TX_READY = pat[0];
          pat = {pat[0], pat[31:1]};
        end
      end
    join
    TX_READY = 1'b1;
    drain();

    // start_port held high: one accept every two cycles.
    c0 = done_cnt;
    start_port = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in1 = 8'hC0 + 8'(k);
      exp_ret.push_back({8'h00, 8'hC0 + 8'(k)});
      exp_tx.push_back(8'hC0 + 8'(k));
      @(posedge clock); #2;
      @(posedge clock); #2;
    end
    start_port = 1'b0;
    chk("held_start_calls", done_cnt - c0, 5);
    drain();

    // Reset while stalled in WAIT_SPACE with a full buffer.
    TX_READY = 1'b0;
    for (int i = 0; i < 17; i++) do_call(8'h20 + 8'(i), lat);
    start_port = 1'b1;
    in1 = 8'h99;
    @(posedge clock); #2;
    start_port = 1'b0;
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_done", {31'd0, done_port}, 0);
    chk("mid_rst_ret", {16'd0, return_port}, 0);
    chk("mid_rst_vld", {31'd0, TX_VALID}, 0);
    chk("mid_rst_dat", {24'd0, TX_DATA}, 0);
    chk("mid_rst_cnt", {27'd0, fifo_count}, 0);
    exp_tx.delete();
    exp_ret.delete();
    repeat (3) begin
      @(negedge clock);
      chk("mid_rst_no_done", {31'd0, done_port}, 0);
    end
    @(posedge clock); #2;
    reset = 1'b1;
    TX_READY = 1'b1;
    @(posedge clock); #2;
    chk("post_rst_cnt", {27'd0, fifo_count}, 0);
    do_call(8'h5A, lat);
    chk("post_rst_lat", lat, 1);
    @(negedge clock);
    chk("post_rst_vld", {31'd0, TX_VALID}, 1);
    chk("post_rst_first", {24'd0, TX_DATA}, 32'h5A);
    @(posedge clock); #2;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
